// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous ram
// between two requesters, one access in flight at a time.
`ifndef DefaultAddrSize
`define DefaultAddrSize 4
`endif
`ifndef DefaultWordSize
`define DefaultWordSize 8
`endif

module ram_arbiter #(
  parameter int AddrSize = `DefaultAddrSize,
  parameter int WordSize = `DefaultWordSize
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [AddrSize-1:0] addr0,
  input  logic [AddrSize-1:0] addr1,
  input  logic [WordSize-1:0] wdata0,
  input  logic [WordSize-1:0] wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic [WordSize-1:0] rdata0,
  output logic [WordSize-1:0] rdata1,
  output logic                busy,
  output logic [AddrSize-1:0] ram_address,
  output logic [WordSize-1:0] ram_in,
  output logic                ram_load,
  input  logic [WordSize-1:0] ram_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                last_grant;
  logic                grant;
  logic                pick;
  logic                any_req;
  logic [WordSize-1:0] hold0;
  logic [WordSize-1:0] hold1;

  assign any_req = req0 | req1;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      ram_address <= '0;
      ram_in      <= '0;
      ram_load    <= 1'b0;
      hold0       <= '0;
      hold1       <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      ack0  <= (state_nx == RESP) && !grant;
      ack1  <= (state_nx == RESP) && grant;
      if (state == IDLE && any_req) begin
        grant       <= pick;
        last_grant  <= pick;
        ram_address <= pick ? addr1 : addr0;
        ram_in      <= pick ? wdata1 : wdata0;
        ram_load    <= pick ? we1 : we0;
      end
      if (state == ISSUE) begin
        ram_load <= 1'b0;
      end
      if (state == RESP) begin
        if (grant) hold1 <= ram_out;
        else       hold0 <= ram_out;
      end
    end
  end

  // ram_out turns valid on the edge that raises ack, so pass it live.
  assign rdata0 = ack0 ? ram_out : hold0;
  assign rdata1 = ack1 ? ram_out : hold1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural ram
// and a scoreboard of expected (port, rdata) acks.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic       we0 = 1'b0;
  logic       we1 = 1'b0;
  logic [3:0] addr0 = 4'd0;
  logic [3:0] addr1 = 4'd0;
  logic [7:0] wdata0 = 8'd0;
  logic [7:0] wdata1 = 8'd0;
  logic       ack0;
  logic       ack1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic       busy;
  logic [3:0] ram_address;
  logic [7:0] ram_in;
  logic       ram_load;
  logic [7:0] ram_out = 8'h00;

  logic [7:0] mem [16] = '{default: 8'h00};
  logic [7:0] model [16] = '{default: 8'h00};

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         ack_cnt0 = 0;
  int         ack_cnt1 = 0;
  int         load_cnt = 0;
  logic [7:0] last_r0 = 8'h00;
  logic [7:0] last_r1 = 8'h00;

  ram_arbiter #(.AddrSize(4), .WordSize(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy),
    .ram_address(ram_address),
    .ram_in(ram_in),
    .ram_load(ram_load),
    .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
    ram_out <= mem[ram_address];
  end

  // Scoreboard monitor: every ack must match the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ram_load) load_cnt++;
      if (!rst_n) begin
        last_r0 = 8'h00;
        last_r1 = 8'h00;
      end
      checks++;
      if (ack0 && ack1) begin
        errors++;
        $display("FAIL dual_ack ack0=%0b ack1=%0b want not both", ack0, ack1);
      end
      if (ack0) begin
        ack_cnt0++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack0 rdata0=%h want no ack", rdata0);
        end else begin
          e = sb.pop_front();
          if (e.port != 0 || rdata0 !== e.data) begin
            errors++;
            $display("FAIL sb_ack0 port=0 rdata0=%h want port=%0d data=%h",
                     rdata0, e.port, e.data);
          end
        end
        last_r0 = rdata0;
        checks++;
        if (rdata1 !== last_r1) begin
          errors++;
          $display("FAIL hold_rdata1 got=%h want=%h", rdata1, last_r1);
        end
      end
      if (ack1) begin
        ack_cnt1++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack1 rdata1=%h want no ack", rdata1);
        end else begin
          e = sb.pop_front();
          if (e.port != 1 || rdata1 !== e.data) begin
            errors++;
            $display("FAIL sb_ack1 port=1 rdata1=%h want port=%0d data=%h",
                     rdata1, e.port, e.data);
          end
        end
        last_r1 = rdata1;
        checks++;
        if (rdata0 !== last_r0) begin
          errors++;
          $display("FAIL hold_rdata0 got=%h want=%h", rdata0, last_r0);
        end
      end
    end
  end

  task automatic push(input int port, input logic [3:0] a,
                      input logic we, input logic [7:0] d);
    exp_t e;
    e.port = port;
    e.data = model[a];
    sb.push_back(e);
    if (we) model[a] = d;
  endtask

  task automatic wait_ack(input int port, input int max, output int cyc);
    cyc = -1;
    for (int c = 1; c <= max; c++) begin
      @(negedge clk);
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        cyc = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, busy, ram_load} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0000",
               {ack0, ack1, busy, ram_load});
    end
    checks++;
    if ({ram_address, ram_in, rdata0, rdata1} !== 28'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0",
               {ram_address, ram_in, rdata0, rdata1});
    end
  endtask

  task automatic test_tie_from_reset();
    int t0 = -1;
    int t1 = -1;
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
    push(0, 4'd1, 1'b0, 8'h00);
    push(1, 4'd2, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (ack0) begin t0 = c; req0 = 1'b0; end
      if (ack1) begin t1 = c; req1 = 1'b0; end
      if (t0 > 0 && t1 > 0) break;
    end
    checks++;
    if (t0 != 2) begin
      errors++;
      $display("FAIL tie_first_ack0 cycle=%0d want=2", t0);
    end
    checks++;
    if (t1 - t0 != 3 || t1 < 0) begin
      errors++;
      $display("FAIL tie_ack1_gap gap=%0d want=3", t1 - t0);
    end
  endtask

  task automatic test_write();
    int c;
    int l0;
    @(negedge clk);
    l0 = load_cnt;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5;
    push(0, 4'd3, 1'b1, 8'hA5);
    wait_ack(0, 8, c);
    req0 = 1'b0; we0 = 1'b0;
    checks++;
    if (c != 2) begin
      errors++;
      $display("FAIL write_latency cycle=%0d want=2", c);
    end
    checks++;
    if (load_cnt - l0 != 1) begin
      errors++;
      $display("FAIL write_load_len got=%0d want=1", load_cnt - l0);
    end
  endtask

  task automatic test_read();
    int c;
    int a0;
    @(negedge clk);
    a0 = ack_cnt0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
    push(1, 4'd3, 1'b0, 8'h00);
    wait_ack(1, 8, c);
    req1 = 1'b0;
    checks++;
    if (c != 2) begin
      errors++;
      $display("FAIL read_latency cycle=%0d want=2", c);
    end
    checks++;
    if (ack_cnt0 != a0) begin
      errors++;
      $display("FAIL read_no_ack0 got=%0d want=%0d", ack_cnt0, a0);
    end
  endtask

  task automatic test_back_to_back();
    logic       w0 [2] = '{1'b1, 1'b0};
    logic [3:0] a0 [2] = '{4'd4, 4'd5};
    logic       w1 [2] = '{1'b1, 1'b0};
    logic [3:0] a1 [2] = '{4'd5, 4'd4};
    int i0 = 0;
    int i1 = 0;
    int run = 0;
    int max_run = 0;
    @(negedge clk);
    push(0, 4'd4, 1'b1, 8'h11);
    push(1, 4'd5, 1'b1, 8'h22);
    push(0, 4'd5, 1'b0, 8'h00);
    push(1, 4'd4, 1'b0, 8'h00);
    req0 = 1'b1; we0 = w0[0]; addr0 = a0[0]; wdata0 = 8'h11;
    req1 = 1'b1; we1 = w1[0]; addr1 = a1[0]; wdata1 = 8'h22;
    for (int c = 0; c < 30 && (i0 < 2 || i1 < 2); c++) begin
      @(negedge clk);
      if (!busy) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (ack0) begin
        i0++;
        if (i0 < 2) begin we0 = w0[i0]; addr0 = a0[i0]; end
        else req0 = 1'b0;
      end
      if (ack1) begin
        i1++;
        if (i1 < 2) begin we1 = w1[i1]; addr1 = a1[i1]; end
        else req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    checks++;
    if (i0 != 2 || i1 != 2) begin
      errors++;
      $display("FAIL b2b_done acks=%0d/%0d want=2/2", i0, i1);
    end
    checks++;
    if (max_run > 1) begin
      errors++;
      $display("FAIL b2b_busy_gap got=%0d want<=1", max_run);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    int a0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 8'h3C;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ram_load !== 1'b1) begin
      errors++;
      $display("FAIL rmid_issue busy=%b load=%b want=1 1", busy, ram_load);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_load, busy, ack0} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_clear got=%b want=000", {ram_load, busy, ack0});
    end
    req0 = 1'b0; we0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a0 = ack_cnt0;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_cnt0 != a0) begin
      errors++;
      $display("FAIL rmid_no_ack got=%0d want=%0d", ack_cnt0, a0);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd7;
    push(0, 4'd7, 1'b0, 8'h00);
    wait_ack(0, 8, c);
    req0 = 1'b0;
    checks++;
    if (c != 2) begin
      errors++;
      $display("FAIL rmid_read cycle=%0d want=2", c);
    end
  endtask

  task automatic test_single_drop();
    int c;
    int a0;
    @(negedge clk);
    a0 = ack_cnt0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
    push(0, 4'd5, 1'b0, 8'h00);
    wait_ack(0, 8, c);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_cnt0 - a0 != 1) begin
      errors++;
      $display("FAIL single_ack_count got=%0d want=1", ack_cnt0 - a0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_drop_mid();
    int c;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd4;
    push(1, 4'd4, 1'b0, 8'h00);
    @(negedge clk);
    req1 = 1'b0;
    wait_ack(1, 6, c);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL drop_mid_ack cycle=%0d want=1", c);
    end
  endtask

  initial begin
    test_reset();
    test_tie_from_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_single_drop();
    test_drop_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
